// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the streaming program loader.
//   st_e        : loader FSM states
//   NOP_DEFAULT : default pad word for partial imem lines (addi x0,x0,0)
//   HOLD_W      : width of the post-load reset-hold counter
//   lane_w()    : lane-index width for a given FETCH_WIDTH (min 1 bit)
package prog_load_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,     // one cycle after reset so in_ready comes up registered
    S_HDR_I,
    S_HDR_D,
    S_INSN,
    S_PAD,
    S_DATA,
    S_RELEASE,
    S_RUN,
    S_ERR
  } st_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  localparam int          HOLD_W      = 4;

  function automatic int lane_w(input int fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

endpackage

// File: rtl/prog_load_ctrl_line_packer.sv
// Packs a stream of instruction words into FETCH_WIDTH-wide imem lines.
//   push      : accept data into the current lane
//   last      : this push is the final instruction; pad the rest with NOP_WORD
//   data      : instruction word
//   lane_last : current lane is FETCH_WIDTH-1 (combinational)
//   fire      : this push completes a line (combinational)
//   line_we   : registered single-cycle write strobe, one cycle after fire
//   line_data : registered packed line, lane 0 in the LSBs
module prog_load_ctrl_line_packer
  import prog_load_ctrl_pkg::*;
#(
  parameter int                  FETCH_WIDTH = 4,
  parameter int                  INSN_LEN    = 32,
  parameter logic [INSN_LEN-1:0] NOP_WORD    = INSN_LEN'(NOP_DEFAULT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic                                 last,
  input  logic [INSN_LEN-1:0]                  data,
  output logic                                 lane_last,
  output logic                                 fire,
  output logic                                 line_we,
  output logic [FETCH_WIDTH-1:0][INSN_LEN-1:0] line_data
);

  localparam int LW = lane_w(FETCH_WIDTH);

  logic [LW-1:0]                        lane;
  logic [FETCH_WIDTH-1:0][INSN_LEN-1:0] lbuf;
  logic [FETCH_WIDTH-1:0][INSN_LEN-1:0] line_nxt;

  assign lane_last = (lane == LW'(FETCH_WIDTH - 1));
  assign fire      = push & (lane_last | last);

  // Line as it would look if written now: earlier lanes from the buffer,
  // the current lane from the incoming word, later lanes padded with NOPs.
  // On a full line the pad branch is never selected.
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign line_nxt[i] = (LW'(i) <  lane) ? lbuf[i] :
                         (LW'(i) == lane) ? data    : NOP_WORD;
  end

  always_ff @(posedge clk) begin
    if (push) lbuf[lane] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane      <= '0;
      line_we   <= 1'b0;
      line_data <= '0;
    end else begin
      line_we <= fire;
      if (push) begin
        lane <= fire ? '0 : lane + LW'(1);
        if (fire) line_data <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Streaming program loader: header (N_I, N_D), N_I instructions packed into
// imem lines, N_D data words into dmem, then releases the core reset after
// RST_HOLD cycles. Header overflow parks the block in ERR until reload/reset.
//   clk, reset            : clock, synchronous active-high reset
//   reload                : restart request, honoured in RUN/ERR only
//   in_valid/in_data/in_ready : word stream handshake
//   imem_we/addr/wdata    : imem line write port (lane 0 in LSBs)
//   dmem_we/addr/wdata    : dmem word write port (byte address)
//   loading               : loader owns the memory ports
//   core_reset            : pipeline reset
//   done / err            : in RUN / sticky header overflow
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int                  INSN_LEN    = 32,
  parameter int                  FETCH_WIDTH = 4,
  parameter int                  IMEM_ADDR_W = 9,
  parameter int                  DMEM_ADDR_W = 32,
  parameter longint unsigned     DMEM_BASE   = 0,
  parameter int                  RST_HOLD    = 2,
  parameter logic [INSN_LEN-1:0] NOP_WORD    = INSN_LEN'(NOP_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reload,
  input  logic                            in_valid,
  input  logic [INSN_LEN-1:0]             in_data,
  output logic                            in_ready,
  output logic                            imem_we,
  output logic [IMEM_ADDR_W-1:0]          imem_addr,
  output logic [FETCH_WIDTH*INSN_LEN-1:0] imem_wdata,
  output logic                            dmem_we,
  output logic [DMEM_ADDR_W-1:0]          dmem_addr,
  output logic [INSN_LEN-1:0]             dmem_wdata,
  output logic                            loading,
  output logic                            core_reset,
  output logic                            done,
  output logic                            err
);

  localparam longint unsigned MAX_NI = longint'(FETCH_WIDTH) << IMEM_ADDR_W;
  localparam int              IC_W   = $clog2(MAX_NI) + 1;
  localparam logic [63:0]     DSPAN  = 64'd1 << DMEM_ADDR_W;

  st_e st, st_nxt;

  logic [INSN_LEN-1:0]    n_i;
  logic [IC_W-1:0]        rem_i;
  logic [INSN_LEN-1:0]    rem_d;
  logic [IMEM_ADDR_W-1:0] line_idx;
  logic [DMEM_ADDR_W-1:0] d_ptr;
  logic [HOLD_W-1:0]      hold_cnt;

  logic        xfer, push, last_i, hdr_bad;
  logic        pk_lane_last, pk_fire;
  logic [63:0] nd_end;
  logic [FETCH_WIDTH-1:0][INSN_LEN-1:0] pk_line;

  assign xfer   = in_valid & in_ready;
  assign push   = xfer & (st == S_INSN);
  assign last_i = (rem_i == IC_W'(1));

  // Header check in 64 bits so a huge N_D cannot wrap past the span.
  assign nd_end  = (64'(in_data) << 2) + 64'(DMEM_BASE);
  assign hdr_bad = (64'(n_i) > 64'(MAX_NI)) | (nd_end > DSPAN);

  prog_load_ctrl_line_packer #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .INSN_LEN    (INSN_LEN),
    .NOP_WORD    (NOP_WORD)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .last      (last_i),
    .data      (in_data),
    .lane_last (pk_lane_last),
    .fire      (pk_fire),
    .line_we   (imem_we),
    .line_data (pk_line)
  );

  assign imem_wdata = pk_line;

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  st_nxt = S_HDR_I;
      S_HDR_I: if (xfer) st_nxt = S_HDR_D;
      S_HDR_D: if (xfer) begin
        if (hdr_bad)              st_nxt = S_ERR;
        else if (n_i != '0)       st_nxt = S_INSN;
        else if (in_data != '0)   st_nxt = S_DATA;
        else                      st_nxt = S_RELEASE;
      end
      S_INSN: if (xfer && last_i) begin
        if (!pk_lane_last)        st_nxt = S_PAD;
        else if (rem_d != '0)     st_nxt = S_DATA;
        else                      st_nxt = S_RELEASE;
      end
      // Padding already happened on the final push; this cycle only
      // carries the imem write with in_ready low.
      S_PAD:     st_nxt = (rem_d != '0) ? S_DATA : S_RELEASE;
      S_DATA:    if (xfer && rem_d == INSN_LEN'(1)) st_nxt = S_RELEASE;
      S_RELEASE: if (hold_cnt == HOLD_W'(RST_HOLD - 1)) st_nxt = S_RUN;
      S_RUN,
      S_ERR:     if (reload) st_nxt = S_HDR_I;
      default:   st_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      loading    <= 1'b1;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready   <= st_nxt inside {S_HDR_I, S_HDR_D, S_INSN, S_DATA};
      loading    <= !(st_nxt inside {S_RELEASE, S_RUN});
      core_reset <= (st_nxt != S_RUN);
      done       <= (st_nxt == S_RUN);
      err        <= (st_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      n_i        <= '0;
      rem_i      <= '0;
      rem_d      <= '0;
      line_idx   <= '0;
      d_ptr      <= DMEM_ADDR_W'(DMEM_BASE);
      hold_cnt   <= '0;
    end else begin
      dmem_we <= 1'b0;
      case (st)
        // Every load (first or after reload) passes through HDR_I, so
        // the per-load counters are cleared here.
        S_HDR_I: begin
          line_idx <= '0;
          d_ptr    <= DMEM_ADDR_W'(DMEM_BASE);
          hold_cnt <= '0;
          if (xfer) n_i <= in_data;
        end
        S_HDR_D: if (xfer) begin
          rem_i <= IC_W'(n_i);
          rem_d <= in_data;
        end
        S_INSN: if (xfer) begin
          rem_i <= rem_i - IC_W'(1);
          if (pk_fire) begin
            imem_addr <= line_idx;
            line_idx  <= line_idx + IMEM_ADDR_W'(1);
          end
        end
        S_DATA: if (xfer) begin
          dmem_we    <= 1'b1;
          dmem_addr  <= d_ptr;
          dmem_wdata <= in_data;
          d_ptr      <= d_ptr + DMEM_ADDR_W'(4);
          rem_d      <= rem_d - INSN_LEN'(1);
        end
        S_RELEASE: hold_cnt <= hold_cnt + HOLD_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;

  localparam int          FW   = 4;
  localparam int          HOLD = 2;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] NOP  = 32'h13;

  logic         clk = 1'b0;
  logic         reset = 1'b1, reload = 1'b0, in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready, imem_we, dmem_we, loading, core_reset, done, err;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic [31:0]  dmem_addr, dmem_wdata;

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .INSN_LEN(32), .FETCH_WIDTH(FW), .IMEM_ADDR_W(9), .DMEM_ADDR_W(32),
    .DMEM_BASE(64'h100), .RST_HOLD(HOLD), .NOP_WORD(32'h13)
  ) dut (
    .clk(clk), .reset(reset), .reload(reload),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .loading(loading), .core_reset(core_reset), .done(done), .err(err)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write monitor
  int          cyc = 0, last_wr_cyc = 0, lf_cyc = 0, cf_cyc = 0;
  logic        prev_ld = 1'b1, prev_cr = 1'b1;
  logic [31:0]  obs_ia[$], obs_da[$], obs_dd[$];
  logic [127:0] obs_id[$];
  logic         obs_ir[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      obs_ia.push_back(32'(imem_addr));
      obs_id.push_back(imem_wdata);
      obs_ir.push_back(in_ready);
      last_wr_cyc <= cyc;
    end
    if (dmem_we) begin
      obs_da.push_back(dmem_addr);
      obs_dd.push_back(dmem_wdata);
      last_wr_cyc <= cyc;
    end
    if (imem_we && dmem_we) chk("we_excl", 128'(1), 128'(0));
    if (prev_ld && !loading)    lf_cyc <= cyc;
    if (prev_cr && !core_reset) cf_cyc <= cyc;
    prev_ld <= loading;
    prev_cr <= core_reset;
  end

  // drive one word; gap is the percent chance of an idle cycle
  task automatic send(input logic [31:0] w, input int gap);
    bit sent = 0;
    for (int g = 0; g < 400 && !sent; g++) begin
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = w;
        sent     = in_ready;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!sent) chk("send_tmo", 128'(0), 128'(1));
  endtask

  task automatic do_reload();
    in_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk("rl_flags", 128'({core_reset, loading, done, err, in_ready}), 128'(5'b11001));
  endtask

  // mode: 0 random words, 1 counting (1.. / A..), 2 fixed pattern
  task automatic run_load(input int ni, input int nd, input int gap, input int mode, input bit rl_mid);
    logic [31:0]  ins[$], dat[$];
    logic [127:0] line;
    int           nl, done_cyc;
    bit           got;
    obs_ia.delete(); obs_id.delete(); obs_ir.delete();
    obs_da.delete(); obs_dd.delete();
    for (int k = 0; k < ni; k++)
      ins.push_back(mode == 1 ? 32'(k + 1) : mode == 2 ? 32'h1000_0000 + 32'(k * 7) : $urandom);
    for (int j = 0; j < nd; j++)
      dat.push_back(mode == 1 ? 32'hA + 32'(j) : mode == 2 ? 32'hD000_0000 + 32'(j * 13) : $urandom);
    send(32'(ni), gap);
    send(32'(nd), gap);
    if (rl_mid) begin
      reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    end
    foreach (ins[k]) send(ins[k], gap);
    foreach (dat[j]) send(dat[j], gap);
    got = 0; done_cyc = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (done) begin got = 1; done_cyc = cyc; end
    end
    chk("done", 128'(got), 128'(1));
    @(posedge clk); #1;
    nl = (ni + FW - 1) / FW;
    chk("imem_cnt", 128'(obs_ia.size()), 128'(nl));
    for (int l = 0; l < nl && l < obs_ia.size(); l++) begin
      line = '0;
      for (int i = 0; i < FW; i++)
        line[i*32 +: 32] = (l*FW + i < ni) ? ins[l*FW + i] : NOP;
      chk("imem_addr", 128'(obs_ia[l]), 128'(l));
      chk("imem_data", obs_id[l], line);
    end
    if (ni % FW != 0 && obs_ir.size() == nl) chk("pad_rdy", 128'(obs_ir[nl-1]), 128'(0));
    chk("dmem_cnt", 128'(obs_da.size()), 128'(nd));
    for (int j = 0; j < nd && j < obs_da.size(); j++) begin
      chk("dmem_addr", 128'(obs_da[j]), 128'(BASE + 32'(4*j)));
      chk("dmem_data", 128'(obs_dd[j]), 128'(dat[j]));
    end
    chk("hold", 128'(cf_cyc - lf_cyc), 128'(HOLD));
    if (ni + nd > 0)
      chk("wr_to_run", 128'(done_cyc - last_wr_cyc),
          128'(HOLD + ((nd == 0 && ni % FW != 0) ? 1 : 0)));
    chk("run_outs", 128'({core_reset, loading, in_ready, err, done}), 128'(5'b00001));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 128'({imem_we, dmem_we, loading, core_reset, done, err, in_ready}), 128'(7'b0011000));
    chk("rst_addr", 128'({imem_addr, dmem_addr}), 128'(0));
    chk("rst_wdata", 128'({imem_wdata, dmem_wdata}), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("hdr_rdy", 128'(in_ready), 128'(1));

    run_load(8, 0, 0, 1, 0);          // two full lines
    do_reload();
    run_load(5, 0, 0, 1, 0);          // partial line -> PAD
    do_reload();
    run_load(0, 3, 0, 1, 0);          // data only at 0x100..
    do_reload();
    run_load(16, 4, 0, 2, 0);         // gap-free reference
    do_reload();
    run_load(16, 4, 50, 2, 1);        // same words with gaps, ignored reload
    do_reload();

    // N_I overflow
    send(32'd2049, 0);
    send(32'd0, 0);
    chk("err_flags", 128'({err, core_reset, in_ready, loading, done}), 128'(5'b11010));
    in_valid = 1'b1; in_data = 32'h55;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    chk("err_hold", 128'({err, in_ready, imem_we, dmem_we}), 128'(4'b1000));
    do_reload();
    run_load(6, 2, 30, 0, 0);
    do_reload();

    // N_D exactly filling the span is legal
    send(32'd0, 0);
    send(32'h3FFF_FFC0, 0);
    chk("nd_edge", 128'({err, in_ready}), 128'(2'b01));
    send(32'h1234, 0);
    chk("nd_edge_wr", 128'({dmem_we, dmem_addr, dmem_wdata}), 128'({1'b1, BASE, 32'h1234}));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // one word past the span
    send(32'd0, 0);
    send(32'h3FFF_FFC1, 0);
    chk("nd_over", 128'({err, in_ready}), 128'(2'b10));
    do_reload();

    // reset mid-INSN
    obs_ia.delete();
    send(32'd8, 0);
    send(32'd0, 0);
    send(32'hDEAD_0001, 0);
    send(32'hDEAD_0002, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid", 128'({loading, core_reset, in_ready, imem_we, dmem_we}), 128'(5'b11000));
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_nowr", 128'(obs_ia.size()), 128'(0));
    run_load(4, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
